netbus_arb3: RTL
================

# netbus_arb3

Packet-aware round-robin arbiter that merges three NetBus source ports onto one NetBus sink port. It is the converging counterpart of the three-way NetBus fan-out: it shares one downstream NetBus link between three requesters. Whole packets are forwarded without interleaving. A one-word registered output stage separates the arbitration logic from the downstream link.

## Interface
- DATA_WIDTH, default 4: NetBus word is DATA_WIDTH*9+14 bits (W). Bit W-1 is EOP (last word of packet).
- CLK  in  1  sole clock, rising edge
- RSTN  in  1  asynchronous reset, active-low
- DATA0 / DATA1 / DATA2  in  W  source words, ports 0..2
- VALID0 / VALID1 / VALID2  in  1  source word valid
- READY0 / READY1 / READY2  out  1  source word accepted (combinational)
- WCLK  out  1  equals CLK
- WDATA  out  W  sink word (registered)
- WVALID  out  1  sink word valid (registered)
- WREADY  in  1  sink accepts word
- GRANT  out  2  current owner: 0..2, 3 = none (registered)
- BUSY  out  1  high while a packet is owned (GRANT != 3)

## Operation
- A transfer happens on a port when VALIDn && READYn (source side) or WVALID && WREADY (sink side) is high at a rising CLK edge.
- Output register: `space = !WVALID || WREADY`. Only the owner sees ready: READYn = (GRANT == n) && space. All other READY outputs are 0.
- An accepted source word loads WDATA on the next edge and sets WVALID=1. If the sink drains the register and no new word is accepted in the same cycle, WVALID=0 and WDATA holds its value.
- State machine:
  - IDLE (GRANT=3): if any VALIDn is high, pick the first requester in the order LAST+1, LAST+2, LAST (mod 3). Register it as the owner and set LAST to it. No word is accepted in the IDLE cycle.
  - LOCK(n) (GRANT=n): forward words from port n. When a word with EOP=1 is accepted from port n, return to IDLE on the next edge.
- Ownership is held through source bubbles. If VALIDn drops in the middle of a packet, the block waits and other ports are not served.
- A single-word packet (EOP=1 on the first word) is valid: one cycle in LOCK, then IDLE.
- Round robin: a port that has just finished a packet has the lowest priority at the next arbitration. Starvation bound is 2 packets.
- The owner's data is never dropped or duplicated. Word order within a port is preserved.

## Timing
- Reset (RSTN low, asynchronous): WVALID=0, WDATA=0, GRANT=3, BUSY=0, LAST=2 (port 0 has first priority), all READYn=0. Takes effect without a clock edge.
- Reset in the middle of a packet: the partial packet is abandoned, including any word in the output register. After release, the block starts in IDLE.
- Latency when the sink is always ready:
  - VALIDn rises in IDLE at cycle 0.
  - GRANT=n from cycle 1 and READYn=1 in cycle 1.
  - First word appears on WVALID/WDATA in cycle 2.
- Throughput inside a packet: 1 word/cycle when WREADY=1 continuously.
- Inter-packet gap: 1 IDLE cycle. Back-to-back packets give exactly one WVALID=0 cycle at the sink if the source streams.
- WREADY low holds WDATA/WVALID stable and forces READYn=0. Transfer resumes in the cycle WREADY returns high.
- EOP accepted on edge k: GRANT=3 after edge k. Re-arbitration is decided during cycle k+1, so the new owner is visible after edge k+1.

## Test plan
- Reset check: drive RSTN=0 in the middle of a cycle -> WVALID=0, WDATA=0, GRANT=3, READY0..2=0 immediately. After release with VALID1 only -> GRANT=1 one edge later.
- Simultaneous request: all ports present 3-word packets from reset -> sink order is port 0 packet, then port 1, then port 2. Exactly one WVALID=0 cycle between packets. Each packet is 3 contiguous words with EOP on the third.
- Round-robin fairness: port 0 streams packets continuously while port 2 requests once -> after the current port-0 packet ends, port 2 is granted before port 0's next packet.
- Sink backpressure: 4-word packet on port 1 with WREADY toggling 1,0,0,1,0,1... -> WDATA holds stable while WREADY=0. Sink receives all 4 words in order with no duplicates. READY1=0 in every cycle where WVALID=1 and WREADY=0.
- Source bubble mid-packet: port 0 sends 2 words, drops VALID0 for 3 cycles while port 1 requests, then sends EOP -> GRANT stays 0 throughout. Port 1 is granted only after port 0's EOP word is accepted.
- Single-word packets: ports 0 and 2 each send EOP-on-first-word packets continuously -> sink alternates port 0 word, port 2 word. GRANT sequence is 0,3,2,3,0,...

Source files
------------

// File: rtl/netbus_arb3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | netbus_arb3 - packet-aware 3:1 round-robin NetBus arbiter, registered out |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module netbus_arb3 #(
    parameter  int DATA_WIDTH = 4,
    localparam int W          = DATA_WIDTH * 9 + 14
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic [W-1:0] DATA0,
    input  logic [W-1:0] DATA1,
    input  logic [W-1:0] DATA2,
    input  logic         VALID0,
    input  logic         VALID1,
    input  logic         VALID2,
    output logic         READY0,
    output logic         READY1,
    output logic         READY2,
    output logic         WCLK,
    output logic [W-1:0] WDATA,
    output logic         WVALID,
    input  logic         WREADY,
    output logic [1:0]   GRANT,
    output logic         BUSY
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    localparam logic [1:0] NO_OWNER = 2'd3;

    state_t       state_q, state_d;
    logic [1:0]   grant_q, grant_d;
    logic [1:0]   last_q, last_d;
    logic [W-1:0] wdata_q, wdata_d;
    logic         wvalid_q, wvalid_d;

    logic [2:0]   valid_vec;
    logic         space;
    logic         owner_valid;
    logic [W-1:0] owner_data;
    logic         accept;
    logic [1:0]   cand1, cand2, pick;
    logic         pick_valid;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign valid_vec = {VALID2, VALID1, VALID0};
    assign space     = !wvalid_q || WREADY;

    // grant_q is NO_OWNER while idle, so no port sees ready outside LOCK.
    assign READY0 = (grant_q == 2'd0) && space;
    assign READY1 = (grant_q == 2'd1) && space;
    assign READY2 = (grant_q == 2'd2) && space;

    always_comb begin
        owner_valid = 1'b0;
        owner_data  = '0;
        case (grant_q)
            2'd0:    begin owner_valid = VALID0; owner_data = DATA0; end
            2'd1:    begin owner_valid = VALID1; owner_data = DATA1; end
            2'd2:    begin owner_valid = VALID2; owner_data = DATA2; end
            default: ;
        endcase
    end

    assign accept = (state_q == S_LOCK) && owner_valid && space;

    // The port that finished last is searched last.
    always_comb begin
        cand1      = inc3(last_q);
        cand2      = inc3(cand1);
        pick       = cand1;
        pick_valid = 1'b1;
        if (valid_vec[cand1]) begin
            pick = cand1;
        end else if (valid_vec[cand2]) begin
            pick = cand2;
        end else if (valid_vec[last_q]) begin
            pick = last_q;
        end else begin
            pick_valid = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d = S_LOCK;
                    grant_d = pick;
                    last_d  = pick;
                end
            end
            S_LOCK: begin
                if (accept && owner_data[W-1]) begin
                    state_d = S_IDLE;
                    grant_d = NO_OWNER;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = NO_OWNER;
            end
        endcase
    end

    always_comb begin
        wdata_d  = wdata_q;
        wvalid_d = wvalid_q;
        if (accept) begin
            wdata_d  = owner_data;
            wvalid_d = 1'b1;
        end else if (WREADY) begin
            wvalid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= S_IDLE;
            grant_q  <= NO_OWNER;
            last_q   <= 2'd2;
            wdata_q  <= '0;
            wvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            wdata_q  <= wdata_d;
            wvalid_q <= wvalid_d;
        end
    end

    assign WCLK   = CLK;
    assign WDATA  = wdata_q;
    assign WVALID = wvalid_q;
    assign GRANT  = grant_q;
    assign BUSY   = (grant_q != NO_OWNER);

endmodule
`default_nettype wire
